alu_op_issuer: RTL and testbench

//  Hardware initiator for the ALU operation interface (op_start/A/B/opcode -> OUT).
//  - Accepts commands on a valid/ready port and buffers them in a small FIFO.
//  - Issues one op at a time: op_start pulse, operands held stable, waits RESP_LAT cycles.
//  - Captures OUT and returns it with the command tag on a valid/ready result port.
//  - Replaces the bench driver/monitor pair when the ALU is embedded in a datapath.

---
 rtl/alu_op_issuer.sv | 175 +++++++++++++++++
 tb/tb_alu_op_issuer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: queues ALU commands in a small FIFO, issues them one at a
// time with a single-cycle op_start pulse, waits the ALU latency, captures
// the result and presents it with the command tag on a valid/ready port.
module alu_op_issuer #(
    parameter int DATA_W   = 8,
    parameter int OP_W     = 3,
    parameter int OUT_W    = 16,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 4,
    parameter int RESP_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              op_start,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   opcode,
    input  logic [OUT_W-1:0]  out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_LAT + 1);
    localparam int CMD_W = 2 * DATA_W + OP_W + TAG_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RESP_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sample;
    logic               res_clear;

    logic [CMD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               full, empty, push, pop;

    logic [DATA_W-1:0]  a_reg, b_reg;
    logic [OP_W-1:0]    op_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               res_valid_reg;
    logic [OUT_W-1:0]   res_data_reg;
    logic [TAG_W-1:0]   res_tag_reg;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign pop   = (state_reg == IDLE) && !empty;
    // A pop frees a slot this cycle, so a full FIFO may still take a command.
    // Held low while reset is asserted so every output reads 0 in reset.
    assign cmd_ready = !rst && (!full || pop);
    assign push      = cmd_valid && cmd_ready;

    // Command storage: plain array written at the tail, read at the head on pop.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    // Operand registers: loaded from the FIFO head on pop, held until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            tag_reg <= '0;
        end else if (pop) begin
            {a_reg, b_reg, op_reg, tag_reg} <= mem[rd_ptr_reg];
        end
    end

    // Next-state logic. The counter is sampled "as it reaches 0", so out is
    // captured on the RESP_LAT-th edge after the edge that raised op_start
    // (RESP_LAT=1 captures straight out of ISSUE).
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sample     = 1'b0;
        res_clear  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty)
                    state_next = ISSUE;
            end
            ISSUE: begin
                cnt_next = LAT_LOAD;
                if (cnt_next == '0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_next == '0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Result holding registers: captured on the sample edge, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_tag_reg   <= '0;
        end else if (sample) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= out;
            res_tag_reg   <= tag_reg;
        end else if (res_clear) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign op_start  = (state_reg == ISSUE);
    assign a         = a_reg;
    assign b         = b_reg;
    assign opcode    = op_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_tag   = res_tag_reg;
    assign busy      = (state_reg != IDLE) || !empty;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: directed vector table, multi-cycle corner
// sequences and a randomized run checked by a queue-based scoreboard.
module tb_alu_op_issuer;

    localparam int DATA_W   = 8;
    localparam int OP_W     = 3;
    localparam int OUT_W    = 16;
    localparam int TAG_W    = 4;
    localparam int DEPTH    = 4;
    localparam int RESP_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a, cmd_b;
    logic [OP_W-1:0]   cmd_op;
    logic [TAG_W-1:0]  cmd_tag;
    logic              op_start;
    logic [DATA_W-1:0] a, b;
    logic [OP_W-1:0]   opcode;
    logic [OUT_W-1:0]  alu_out;
    logic              res_valid;
    logic              res_ready;
    logic [OUT_W-1:0]  res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;

    alu_op_issuer #(
        .DATA_W(DATA_W), .OP_W(OP_W), .OUT_W(OUT_W),
        .TAG_W(TAG_W), .DEPTH(DEPTH), .RESP_LAT(RESP_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .op_start(op_start), .a(a), .b(b), .opcode(opcode),
        .out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU function.
    function automatic logic [15:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        case (o)
            3'd0:    return 16'(x) + 16'(y);
            3'd1:    return 16'(x) - 16'(y);
            3'd2:    return {8'h00, x & y};
            3'd3:    return {8'h00, x | y};
            3'd4:    return {8'h00, x ^ y};
            3'd5:    return 16'(x) * 16'(y);
            3'd6:    return {x, y};
            default: return {y, x};
        endcase
    endfunction

    // ALU model: result is only valid during the cycle before the RESP_LAT-th
    // edge after op_start was raised; any other time it drives junk.
    logic [3:0] age;
    always @(posedge clk or posedge rst) begin
        if (rst)
            age <= 4'd0;
        else if (op_start)
            age <= 4'd1;
        else if (age != 4'd0 && age != 4'd15)
            age <= age + 4'd1;
    end
    assign alu_out = (age == 4'(RESP_LAT - 1)) ? alu_f(a, b, opcode) : (16'hDEAD ^ {12'h000, age});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: commands accepted but not yet issued, and expected results in order.
    typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [3:0] tag; } cmd_t;
    typedef struct { logic [15:0] data; logic [3:0] tag; } res_t;
    cmd_t pend_q[$];
    res_t exp_q[$];
    cmd_t held;
    logic track = 1'b0;
    logic prev_start = 1'b0;

    // Monitor: observes handshakes on the falling edge (inputs and outputs are stable).
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            track = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                pend_q.push_back('{cmd_a, cmd_b, cmd_op, cmd_tag});
                exp_q.push_back('{alu_f(cmd_a, cmd_b, cmd_op), cmd_tag});
            end
            if (op_start) begin
                n_starts++;
                chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
                chk("issue_has_cmd", {31'd0, pend_q.size() != 0}, 32'd1);
                if (pend_q.size() != 0) begin
                    held = pend_q.pop_front();
                    chk("issue_a", {24'd0, a}, {24'd0, held.a});
                    chk("issue_b", {24'd0, b}, {24'd0, held.b});
                    chk("issue_op", {29'd0, opcode}, {29'd0, held.op});
                end
                track = 1'b1;
            end else if (track) begin
                if (res_valid) begin
                    track = 1'b0;
                end else begin
                    chk("stable_a", {24'd0, a}, {24'd0, held.a});
                    chk("stable_b", {24'd0, b}, {24'd0, held.b});
                    chk("stable_op", {29'd0, opcode}, {29'd0, held.op});
                end
            end
            prev_start = op_start;
            if (res_valid && res_ready) begin
                chk("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    res_t e;
                    e = exp_q.pop_front();
                    $display("[TB] result tag=%0d data=%h expect tag=%0d data=%h", res_tag, res_data, e.tag, e.data);
                    chk("sb_data", {16'd0, res_data}, {16'd0, e.data});
                    chk("sb_tag", {28'd0, res_tag}, {28'd0, e.tag});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted; waited = cycles refused.
    task automatic push(input logic [7:0] pa, input logic [7:0] pb, input logic [2:0] po,
                        input logic [3:0] pt, output int waited);
        logic ok;
        waited = 0;
        cmd_valid = 1'b1; cmd_a = pa; cmd_b = pb; cmd_op = po; cmd_tag = pt;
        ok = 1'b0;
        while (!ok && waited < 500) begin
            @(negedge clk);
            ok = cmd_ready;
            tick();
            if (!ok) waited++;
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    // Count edges until res_valid is seen; leaves time at that falling edge.
    task automatic wait_rv(output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (res_valid) break;
            if (cycles >= 100) begin
                chk("res_valid_timeout", 32'd0, 32'd1);
                cycles = -1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy && !res_valid) done = 1'b1;
            tick();
        end
        chk("drain_done", {31'd0, done}, 32'd1);
        chk("drain_sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_zero(input string where);
        chk({where, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        chk({where, "_op_start"}, {31'd0, op_start}, 32'd0);
        chk({where, "_a"}, {24'd0, a}, 32'd0);
        chk({where, "_b"}, {24'd0, b}, 32'd0);
        chk({where, "_opcode"}, {29'd0, opcode}, 32'd0);
        chk({where, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({where, "_res_data"}, {16'd0, res_data}, 32'd0);
        chk({where, "_res_tag"}, {28'd0, res_tag}, 32'd0);
        chk({where, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [3:0] tag; logic [15:0] exp; } vec_t;
    vec_t vecs[9];

    initial begin
        int w, lat, s0, sent, guard;
        logic acc;
        logic [15:0] hold_data;
        logic [3:0]  hold_tag;

        vecs[0] = '{8'h05, 8'h03, 3'd0, 4'd1, 16'h0008};
        vecs[1] = '{8'h0A, 8'h03, 3'd1, 4'd2, 16'h0007};
        vecs[2] = '{8'hF0, 8'h3C, 3'd2, 4'd3, 16'h0030};
        vecs[3] = '{8'hF0, 8'h0F, 3'd3, 4'd4, 16'h00FF};
        vecs[4] = '{8'hFF, 8'h0F, 3'd4, 4'd5, 16'h00F0};
        vecs[5] = '{8'h10, 8'h10, 3'd5, 4'd6, 16'h0100};
        vecs[6] = '{8'h12, 8'h34, 3'd6, 4'd7, 16'h1234};
        vecs[7] = '{8'h12, 8'h34, 3'd7, 4'd8, 16'h3412};
        vecs[8] = '{8'h00, 8'h01, 3'd1, 4'd9, 16'hFFFF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        check_zero("por");
        @(negedge clk); #1 rst = 1'b0;
        tick();

        // Reset in the middle of WAIT with two commands still queued.
        res_ready = 1'b1;
        push(8'h11, 8'h22, 3'd0, 4'hA, w);
        push(8'h33, 8'h44, 3'd1, 4'hB, w);
        push(8'h55, 8'h66, 3'd2, 4'hC, w);
        chk("pre_reset_a", {24'd0, a}, 32'h11);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check_zero("mid_reset");
        tick();
        check_zero("held_reset");
        @(negedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_no_start", {31'd0, op_start}, 32'd0);
            chk("post_reset_idle", {31'd0, busy}, 32'd0);
            tick();
        end

        // Vector table: single ops from idle.
        for (int i = 0; i < 9; i++) begin
            s0 = n_starts;
            push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, w);
            wait_rv(lat);
            chk("vec_latency", lat, RESP_LAT + 1);
            chk("vec_data", {16'd0, res_data}, {16'd0, vecs[i].exp});
            chk("vec_tag", {28'd0, res_tag}, {28'd0, vecs[i].tag});
            chk("vec_one_start", n_starts - s0, 32'd1);
            tick();
            @(negedge clk);
            chk("vec_res_cleared", {31'd0, res_valid}, 32'd0);
            tick();
        end

        // Fill: one op stalled in RESP, four queued, FIFO full.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(8'(8'h20 + i), 8'(8'h07 * i), 3'(i), 4'(i), w);
        cmd_valid = 1'b1; cmd_a = 8'h99; cmd_b = 8'h77; cmd_op = 3'd5; cmd_tag = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_not_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        res_ready = 1'b1;
        push(8'h99, 8'h77, 3'd5, 4'd5, w);
        chk("push_on_pop_wait", w, 32'd1);
        @(negedge clk);
        chk("still_full_after_swap", {31'd0, cmd_ready}, 32'd0);
        tick();
        drain();

        // Backpressure: result held for 10 cycles, no new issue.
        res_ready = 1'b0;
        push(8'h81, 8'h02, 3'd5, 4'd3, w);
        push(8'h0C, 8'h0A, 3'd4, 4'd4, w);
        wait_rv(lat);
        hold_data = res_data;
        hold_tag  = res_tag;
        chk("bp_first_data", {16'd0, hold_data}, {16'd0, alu_f(8'h81, 8'h02, 3'd5)});
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_data", {16'd0, res_data}, {16'd0, hold_data});
            chk("bp_tag", {28'd0, res_tag}, {28'd0, hold_tag});
            chk("bp_no_start", {31'd0, op_start}, 32'd0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_no_start", {31'd0, op_start}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_idle_cycle", {31'd0, op_start}, 32'd0);
        chk("bp_res_cleared", {31'd0, res_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_next_issue", {31'd0, op_start}, 32'd1);
        tick();
        drain();

        // Randomized traffic with random backpressure.
        sent = 0;
        guard = 0;
        while (sent < 200 && guard < 20000) begin
            if (!cmd_valid && ($urandom_range(0, 3) != 0)) begin
                cmd_valid = 1'b1;
                cmd_a = 8'($urandom); cmd_b = 8'($urandom);
                cmd_op = 3'($urandom); cmd_tag = 4'(sent);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                sent++;
                cmd_valid = 1'b0;
            end
            guard++;
        end
        chk("random_all_sent", sent, 32'd200);
        cmd_valid = 1'b0;
        drain();
        chk("random_no_pending", pend_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
